// File: rtl/dbus_arbiter.sv
// dbus_arbiter: round-robin two-master arbiter for the decoder data-bus port.
// Serialises single word transactions and returns read data after RD_LAT cycles.
module dbus_arbiter #(
   parameter int RD_LAT = 1,
   parameter int AW     = 32,
   parameter int DW     = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          wen0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          ack0,
   output logic [DW-1:0] rdata0,
   input  logic          req1,
   input  logic          wen1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          ack1,
   output logic [DW-1:0] rdata1,
   output logic [AW-1:0] bus_addr,
   output logic [DW-1:0] bus_wdata,
   output logic          bus_ren,
   output logic          bus_wen,
   input  logic [DW-1:0] bus_rdata,
   output logic          busy,
   output logic          owner
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
   state_t     r_state, w_next;
   logic [2:0] r_cnt;
   logic       w_any, w_win, w_wen;
   assign w_any = req0 | req1;
   // on a tie the master that did not own the bus last goes next
   assign w_win = (req0 & req1) ? ~owner : req1;
   assign w_wen = w_win ? wen1 : wen0;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end
   // bus_wen is still high during ISSUE for writes, so it doubles as the latched direction
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_any ? ISSUE : IDLE;
         ISSUE:   w_next = bus_wen ? ACK : WAIT;
         WAIT:    w_next = (r_cnt == 3'd0) ? ACK : WAIT;
         ACK:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         rdata0    <= '0;
         rdata1    <= '0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_ren   <= 1'b0;
         bus_wen   <= 1'b0;
         busy      <= 1'b0;
         owner     <= 1'b1;
         r_cnt     <= 3'd0;
      end else begin
         case (r_state)
            IDLE: if (w_any) begin
               bus_addr  <= w_win ? addr1 : addr0;
               bus_wdata <= w_win ? wdata1 : wdata0;
               bus_wen   <= w_wen;
               bus_ren   <= ~w_wen;
               owner     <= w_win;
               busy      <= 1'b1;
            end
            ISSUE: begin
               bus_ren <= 1'b0;
               bus_wen <= 1'b0;
               r_cnt   <= 3'(RD_LAT - 1);
               if (bus_wen) begin
                  ack0 <= ~owner;
                  ack1 <= owner;
               end
            end
            WAIT: if (r_cnt == 3'd0) begin
               if (owner) rdata1 <= bus_rdata;
               else       rdata0 <= bus_rdata;
               ack0 <= ~owner;
               ack1 <= owner;
            end else begin
               r_cnt <= r_cnt - 3'd1;
            end
            ACK: begin
               ack0 <= 1'b0;
               ack1 <= 1'b0;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: directed vector table plus hand sequences for latency, reset and arrival order.
module tb_dbus_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        req0, wen0, req1, wen1;
   logic [31:0] addr0, wdata0, addr1, wdata1, brd;
   logic        a_ack0, a_ack1, a_ren, a_wen, a_busy, a_own;
   logic [31:0] a_rd0, a_rd1, a_addr, a_wd;
   logic        b_ack0, b_ack1, b_ren, b_wen, b_busy, b_own;
   logic [31:0] b_rd0, b_rd1, b_addr, b_wd;
   int          checks = 0;
   int          errors = 0;
   always #5 clk = ~clk;
   dbus_arbiter u1 (
      .clk(clk), .rst(rst),
      .req0(req0), .wen0(wen0), .addr0(addr0), .wdata0(wdata0), .ack0(a_ack0), .rdata0(a_rd0),
      .req1(req1), .wen1(wen1), .addr1(addr1), .wdata1(wdata1), .ack1(a_ack1), .rdata1(a_rd1),
      .bus_addr(a_addr), .bus_wdata(a_wd), .bus_ren(a_ren), .bus_wen(a_wen), .bus_rdata(brd),
      .busy(a_busy), .owner(a_own)
   );
   dbus_arbiter #(.RD_LAT(3)) u3 (
      .clk(clk), .rst(rst),
      .req0(req0), .wen0(wen0), .addr0(addr0), .wdata0(wdata0), .ack0(b_ack0), .rdata0(b_rd0),
      .req1(req1), .wen1(wen1), .addr1(addr1), .wdata1(wdata1), .ack1(b_ack1), .rdata1(b_rd1),
      .bus_addr(b_addr), .bus_wdata(b_wd), .bus_ren(b_ren), .bus_wen(b_wen), .bus_rdata(brd),
      .busy(b_busy), .owner(b_own)
   );
   typedef struct {
      logic [1:0]  c0;
      logic [31:0] a0, d0;
      logic [1:0]  c1;
      logic [31:0] a1, d1, brd;
      logic [5:0]  ef;
      logic [31:0] ea, ed, er0, er1;
   } vec_t;
   vec_t v[$];
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", n, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      {req0, wen0, req1, wen1} = 4'b0;
      addr0 = 0; wdata0 = 0; addr1 = 0; wdata1 = 0; brd = 0;
      step();
      rst = 1'b0;
   endtask
   function automatic logic [31:0] fa();
      return 32'({a_ack0, a_ack1, a_ren, a_wen, a_busy, a_own});
   endfunction
   function automatic logic [31:0] fb();
      return 32'({b_ack0, b_ack1, b_ren, b_wen, b_busy, b_own});
   endfunction
   initial begin
      logic w;
      // flags are {ack0, ack1, bus_ren, bus_wen, busy, owner}
      v.push_back('{2'b11, 32'h100, 32'hDEADBEEF, 2'b00, 32'h0, 32'h0, 32'h0, 6'b000110, 32'h100, 32'hDEADBEEF, 32'h0, 32'h0});
      v.push_back('{2'b11, 32'h100, 32'hDEADBEEF, 2'b00, 32'h0, 32'h0, 32'h0, 6'b100010, 32'h100, 32'hDEADBEEF, 32'h0, 32'h0});
      v.push_back('{2'b00, 32'h100, 32'hDEADBEEF, 2'b00, 32'h0, 32'h0, 32'h0, 6'b000000, 32'h100, 32'hDEADBEEF, 32'h0, 32'h0});
      v.push_back('{2'b00, 32'h100, 32'hDEADBEEF, 2'b00, 32'h0, 32'h0, 32'h0, 6'b000000, 32'h100, 32'hDEADBEEF, 32'h0, 32'h0});
      v.push_back('{2'b00, 32'h100, 32'hDEADBEEF, 2'b10, 32'h200, 32'h0, 32'h0, 6'b001011, 32'h200, 32'h0, 32'h0, 32'h0});
      v.push_back('{2'b00, 32'h100, 32'hDEADBEEF, 2'b10, 32'h200, 32'h0, 32'hAAAAAAAA, 6'b000011, 32'h200, 32'h0, 32'h0, 32'h0});
      v.push_back('{2'b00, 32'h100, 32'hDEADBEEF, 2'b10, 32'h200, 32'h0, 32'h12345678, 6'b010011, 32'h200, 32'h0, 32'h0, 32'h12345678});
      v.push_back('{2'b00, 32'h100, 32'hDEADBEEF, 2'b00, 32'h200, 32'h0, 32'h55555555, 6'b000001, 32'h200, 32'h0, 32'h0, 32'h12345678});
      for (int t = 0; t < 6; t++) begin
         logic [31:0] ea, ed;
         w  = t[0];
         ea = w ? 32'h20 : 32'h10;
         ed = w ? 32'hB1 : 32'hA0;
         v.push_back('{2'b11, 32'h10, 32'hA0, 2'b11, 32'h20, 32'hB1, 32'h0, {4'b0001, 1'b1, w}, ea, ed, 32'h0, 32'h12345678});
         v.push_back('{2'b11, 32'h10, 32'hA0, 2'b11, 32'h20, 32'hB1, 32'h0, {~w, w, 3'b001, w}, ea, ed, 32'h0, 32'h12345678});
         v.push_back('{(t == 5) ? 2'b00 : 2'b11, 32'h10, 32'hA0, (t == 5) ? 2'b00 : 2'b11, 32'h20, 32'hB1, 32'h0,
                       {5'b00000, w}, ea, ed, 32'h0, 32'h12345678});
      end
      do_reset();
      chk("reset flags", fa(), 32'b000001);
      chk("reset bus_addr", a_addr, 32'h0);
      chk("reset bus_wdata", a_wd, 32'h0);
      chk("reset rdata0", a_rd0, 32'h0);
      chk("reset rdata1", a_rd1, 32'h0);
      foreach (v[i]) begin
         {req0, wen0} = v[i].c0; addr0 = v[i].a0; wdata0 = v[i].d0;
         {req1, wen1} = v[i].c1; addr1 = v[i].a1; wdata1 = v[i].d1;
         brd = v[i].brd;
         step();
         chk($sformatf("vec%0d flags", i), fa(), 32'(v[i].ef));
         chk($sformatf("vec%0d bus_addr", i), a_addr, v[i].ea);
         chk($sformatf("vec%0d bus_wdata", i), a_wd, v[i].ed);
         chk($sformatf("vec%0d rdata0", i), a_rd0, v[i].er0);
         chk($sformatf("vec%0d rdata1", i), a_rd1, v[i].er1);
      end
      // RD_LAT=3 master-0 read with a glitch one cycle before the capture cycle
      do_reset();
      req0 = 1; wen0 = 0; addr0 = 32'h300;
      step();
      chk("lat3 issue flags", fb(), 32'b001010);
      chk("lat3 issue addr", b_addr, 32'h300);
      step();
      chk("lat3 wait1 flags", fb(), 32'b000010);
      step();
      brd = 32'hBAD0BAD0;
      step();
      chk("lat3 glitch ack", fb(), 32'b000010);
      chk("lat3 glitch rdata0", b_rd0, 32'h0);
      brd = 32'hCAFEF00D;
      step();
      chk("lat3 ack flags", fb(), 32'b100010);
      chk("lat3 rdata0", b_rd0, 32'hCAFEF00D);
      chk("lat3 rdata1", b_rd1, 32'h0);
      req0 = 0; brd = 0;
      step();
      chk("lat3 idle flags", fb(), 32'b000000);
      // asynchronous reset while both instances sit in WAIT
      do_reset();
      req0 = 1; wen0 = 0; addr0 = 32'h400;
      step();
      step();
      chk("rst pre busy", 32'(b_busy), 32'h1);
      rst = 1;
      #1;
      chk("rst async flags u3", fb(), 32'b000001);
      chk("rst async flags u1", fa(), 32'b000001);
      chk("rst async addr", a_addr, 32'h0);
      step();
      rst = 0;
      step();
      chk("rst regrant flags", fa(), 32'b001010);
      chk("rst regrant addr", a_addr, 32'h400);
      step();
      brd = 32'h0000600D;
      step();
      chk("rst done flags", fa(), 32'b100010);
      chk("rst done rdata0", a_rd0, 32'h0000600D);
      req0 = 0; brd = 0;
      step();
      // req1 arriving during master-0 WAIT waits for IDLE, then wins the tie
      do_reset();
      req0 = 1; wen0 = 0; addr0 = 32'h700;
      step();
      step();
      req1 = 1; wen1 = 1; addr1 = 32'h500; wdata1 = 32'h77;
      step();
      chk("late wait2 flags", fb(), 32'b000010);
      step();
      chk("late wait3 flags", fb(), 32'b000010);
      brd = 32'h13579BDF;
      step();
      chk("late ack0 flags", fb(), 32'b100010);
      chk("late rdata0", b_rd0, 32'h13579BDF);
      step();
      chk("late idle flags", fb(), 32'b000000);
      step();
      chk("late grant1 flags", fb(), 32'b000111);
      chk("late grant1 addr", b_addr, 32'h500);
      chk("late grant1 wdata", b_wd, 32'h77);
      step();
      chk("late ack1 flags", fb(), 32'b010011);
      req1 = 0;
      step();
      step();
      chk("late regrant0 flags", fb(), 32'b001010);
      chk("late regrant0 addr", b_addr, 32'h700);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Two-master arbiter for the single data-bus port that feeds the address decoder (RAM, screen, button, counters).
- Master 0 is the CPU load/store unit; master 1 is a DMA/screen-fill engine.
- Serialises their word transactions with round-robin fairness and drives one request at a time onto the decoder.
- Waits a fixed read latency before returning load data to the owning master.

Parameters:
- RD_LAT, 1, cycles from the bus issue cycle to valid bus_rdata (legal 1..7).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  master 0 request; held until ack0.
- wen0  in  1  master 0: 1 = write, 0 = read (stable while req0).
- addr0  in  AW  master 0 byte address.
- wdata0  in  DW  master 0 write data.
- ack0  out  1  one-cycle completion pulse to master 0.
- rdata0  out  DW  master 0 read data, valid while ack0=1.
- req1, wen1, addr1, wdata1, ack1, rdata1: same as above for master 1.
- bus_addr  out  AW  address to the decoder.
- bus_wdata  out  DW  write data to the decoder.
- bus_ren  out  1  read strobe to the decoder.
- bus_wen  out  1  write strobe to the decoder.
- bus_rdata  in  DW  decoder read-data return.
- busy  out  1  a transaction is in flight (state != IDLE).
- owner  out  1  index of the current or last granted master.

Behaviour:
- All outputs are registered.
- Reset values: ack0/1=0, rdata0/1=0, bus_addr=0, bus_wdata=0, bus_ren=0, bus_wen=0, busy=0, owner=1 (so master 0 wins the first tie). State=IDLE, latency counter=0.
- States:
  - IDLE:
    - If no req: stay.
    - If only one req: grant it.
    - If both req: grant !owner (round-robin).
    - On grant: latch addr/wdata/wen of the winner into bus_addr/bus_wdata; set bus_ren=!wen and bus_wen=wen; set owner=winner, busy=1; go to ISSUE.
  - ISSUE (exactly 1 cycle, strobe visible on the bus):
    - Clear bus_ren and bus_wen at the end of the cycle.
    - Write: go to ACK.
    - Read: load cnt=RD_LAT-1, go to WAIT.
  - WAIT:
    - If cnt==0: capture bus_rdata into rdata[owner], go to ACK.
    - Else: cnt-1.
  - ACK: assert ack[owner] for exactly 1 cycle, clear busy, go to IDLE.
- Latency from the IDLE cycle that samples req to ack: write = 2 cycles; read = 2+RD_LAT cycles (3 at default).
- bus_addr and bus_wdata hold their value after ISSUE until the next grant. Only the strobes are pulses.
- Handshake:
  - A request is consumed in the cycle its ack is high.
  - req still high in the cycle after ack is a new back-to-back request.
  - Masters must not change wen/addr/wdata while req is high and unacked.
  - The arbiter ignores changes after the grant, because the values are latched.
- Read data:
  - rdataN is updated only when master N's read completes; otherwise it holds.
  - Write acks leave rdataN unchanged.
- Fairness: with both masters continuously requesting, grants strictly alternate 0,1,0,1… No master waits more than one foreign transaction.
- Only one ack is ever high per cycle. ack0 and ack1 are never simultaneous.
- Requests arriving during ISSUE, WAIT or ACK are not sampled until IDLE.
- Reset mid-transaction:
  - All state returns to the reset values immediately (asynchronously).
  - No ack is issued for the aborted transaction; any strobe in flight is dropped.
  - owner returns to 1.
- Addresses are passed unmodified (no alignment checks). Decoding belongs to the downstream decoder.

Test Plan:
- Single write: req0=1, wen0=1, addr0=0x100, wdata0=0xDEADBEEF → bus_wen=1 with bus_addr=0x100 and bus_wdata=0xDEADBEEF in cycle 1 after sampling; ack0 in cycle 2; bus_ren never asserted; busy high for cycles 1–2.
- Single read (RD_LAT=1): req1=1, wen1=0, addr1=0x200; model returns 0x12345678 one cycle after the bus_ren cycle → ack1 pulse in cycle 3 with rdata1=0x12345678; rdata0 unchanged.
- Simultaneous requests from reset: req0 and req1 rise together, both writes → master 0 is granted first (owner=0), then master 1. Keeping both high for 6 transactions gives owner sequence 0,1,0,1,0,1 and acks alternating every 3 cycles (IDLE→ISSUE→ACK).
- Read latency sweep: RD_LAT=3, master-0 read → bus_rdata captured exactly 3 cycles after ISSUE; ack0 arrives 5 cycles after sampling; a bus_rdata glitch value driven 2 cycles after ISSUE is not captured.
- Reset mid-read: assert rst during WAIT → bus_ren, busy, ack0 and ack1 go to 0 immediately; owner=1. After deassertion, a pending req0 is re-granted from IDLE and completes normally.
- Late arrival: req1 rises while master 0's read is in WAIT → req1 is not granted until IDLE after ack0. It is then granted first even if req0 is still high (round-robin).
